input_conditioner: RTL and testbench
====================================

INPUT_CONDITIONER -- requirements
Module: input_conditioner

Interface
REQ-001 Parameter SYNC_STAGES, default 2: number of synchronizer flip-flops on the raw input, legal range 2..4.
REQ-002 Parameter WAIT_CYCLES, default 4: number of consecutive cycles the new level must hold before it is accepted, legal range 1..65535.
REQ-003 Port clk, input, 1 bit: the single clock; all logic updates on the rising edge.
REQ-004 Port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 Port noisy_in, input, 1 bit: raw asynchronous level, for example a push-button.
REQ-006 Port clean_out, output, 1 bit: debounced level that feeds the downstream edge-detect stage.
REQ-007 Port busy, output, 1 bit: high while a candidate transition is being qualified.
REQ-008 Port glitch_count, output, 8 bits: count of rejected candidate transitions; saturates at 255.

Function
REQ-009 noisy_in SHALL pass through a SYNC_STAGES-deep flip-flop chain; the last stage (sync_q) is the only signal the FSM uses.
REQ-010 The FSM SHALL have four states: LOW, RISE, HIGH, FALL.
REQ-011 In LOW: clean_out=0; if sync_q=1, go to RISE and load the counter with 0; otherwise stay in LOW.
REQ-012 In RISE, if sync_q=0: go to LOW and increment glitch_count (saturating); clean_out stays 0.
REQ-013 In RISE, if sync_q=1 and counter=WAIT_CYCLES-1: go to HIGH and set clean_out to 1 on the same edge.
REQ-014 In RISE, otherwise: increment the counter.
REQ-015 HIGH and FALL SHALL mirror LOW and RISE with the polarity inverted.
- HIGH: clean_out=1; sync_q=0 moves to FALL.
- FALL: sync_q=1 returns to HIGH and increments glitch_count; the qualify-expiry moves to LOW with clean_out=0.
REQ-016 busy SHALL be 1 exactly when the state is RISE or FALL; it is a registered output.
REQ-017 Counter width SHALL be 16 bits; it never wraps, because qualification ends at WAIT_CYCLES-1.
REQ-018 Latency: number the first rising edge that samples a new, steady noisy_in level as edge 1; clean_out SHALL change on edge SYNC_STAGES+WAIT_CYCLES+1 and not before.
REQ-019 A level held for fewer than WAIT_CYCLES+1 consecutive samples at sync_q SHALL NOT change clean_out.
REQ-020 Each aborted qualification SHALL increment glitch_count by exactly 1.
REQ-021 Once glitch_count reaches 255 it SHALL hold at 255 until reset.
REQ-022 If the level reverts on the same edge on which the counter reaches WAIT_CYCLES-1, the reversion wins: no transition, and the event counts as a glitch.
REQ-023 clean_out SHALL change by at most one transition per qualification, and SHALL never change while the state is LOW or HIGH.

Reset
REQ-024 On a reset sampled at a rising edge, the block SHALL clear all synchronizer flops to 0 and set state=LOW, counter=0, clean_out=0, busy=0, glitch_count=0.
REQ-025 Reset SHALL take priority over every other event, including a qualification in progress; after reset is released, a held-high noisy_in requalifies from scratch.
REQ-026 With reset held and noisy_in=1, the outputs SHALL remain at their reset values.

Verification (SYNC_STAGES=2, WAIT_CYCLES=4)
REQ-027 Clean rise: noisy_in goes 0->1 before edge 1 and is held -> clean_out=1 from edge 7 onward, busy=1 during edges 3..6, glitch_count=0.
REQ-028 Glitch rejection: noisy_in is 1 for 2 cycles, then 0 -> clean_out stays 0 throughout and glitch_count=1 after the pulse has propagated.
REQ-029 Bounce train: 5 short pulses of 1-3 cycles, then a steady 1 -> exactly one 0->1 on clean_out and glitch_count=5.
REQ-030 Mid-qualification reset: reset is asserted at edge 4 of a rise and released at edge 6, with noisy_in still 1 -> clean_out=0 and glitch_count=0 at edge 6; clean_out=1 six edges after the first post-reset sample (i.e. SYNC_STAGES+WAIT_CYCLES+1 counted from that sample).
REQ-031 Saturation: 300 two-cycle pulses -> glitch_count=255 and held there, clean_out=0.
REQ-032 Fall path: from the HIGH state, noisy_in goes to 0 and is held -> clean_out=0 on edge 7; a 1-cycle high blip during FALL yields glitch_count+1 and clean_out stays 1.

Source files
------------

// File: rtl/input_conditioner.sv
// input_conditioner: synchronize a raw level and debounce it through a four-state qualify FSM.
// Ports: clk, reset (sync, active-high), noisy_in (raw async level),
//        clean_out (debounced level), busy (qualifying a candidate edge),
//        glitch_count (saturating count of rejected candidates).
module input_conditioner #(
  parameter int SYNC_STAGES = 2,
  parameter int WAIT_CYCLES = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       noisy_in,
  output logic       clean_out,
  output logic       busy,
  output logic [7:0] glitch_count
);
  typedef enum logic [1:0] {LOW, RISE, HIGH, FALL} state_t;
  localparam logic [15:0] LAST = 16'(WAIT_CYCLES - 1);
  logic [SYNC_STAGES-1:0] sync_chain_q, sync_chain_d;
  logic                   sync_q;
  state_t                 state_q, state_d;
  logic [15:0]            cnt_q, cnt_d;
  logic [7:0]             glitch_q, glitch_d;
  logic                   clean_q, clean_d, busy_q, busy_d;
  assign sync_q       = sync_chain_q[SYNC_STAGES-1];
  assign clean_out    = clean_q;
  assign busy         = busy_q;
  assign glitch_count = glitch_q;
  always_comb begin
    sync_chain_d = {sync_chain_q[SYNC_STAGES-2:0], noisy_in};
    state_d      = state_q;
    cnt_d        = cnt_q;
    glitch_d     = glitch_q;
    unique case (state_q)
      LOW: if (sync_q) begin
        state_d = RISE;
        cnt_d   = '0;
      end
      HIGH: if (!sync_q) begin
        state_d = FALL;
        cnt_d   = '0;
      end
      RISE, FALL: begin
        // a reverted level is checked before expiry so it wins on the final count
        if (sync_q == (state_q == FALL)) begin
          state_d  = state_q == RISE ? LOW : HIGH;
          glitch_d = glitch_q == 8'hff ? glitch_q : glitch_q + 8'd1;
        end else if (cnt_q == LAST) begin
          state_d = state_q == RISE ? HIGH : LOW;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      default: state_d = LOW;
    endcase
    clean_d = state_d == HIGH || state_d == FALL;
    busy_d  = state_d == RISE || state_d == FALL;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_chain_q <= '0;
      state_q      <= LOW;
      cnt_q        <= '0;
      glitch_q     <= '0;
      clean_q      <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      sync_chain_q <= sync_chain_d;
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      glitch_q     <= glitch_d;
      clean_q      <= clean_d;
      busy_q       <= busy_d;
    end
  end
endmodule

// File: tb/tb_input_conditioner.sv
// tb_input_conditioner: scoreboard bench for input_conditioner at SYNC_STAGES=2, WAIT_CYCLES=4.
module tb_input_conditioner;
  localparam int S   = 2;
  localparam int W   = 4;
  localparam int LAT = S + W + 1;
  typedef struct packed {
    logic       clean;
    logic       busy;
    logic [7:0] glitch;
  } exp_t;
  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       noisy_in = 1'b0;
  logic       clean_out, busy;
  logic [7:0] glitch_count;
  exp_t       q[$];
  exp_t       e;
  int         total = 0;
  int         bad = 0;
  input_conditioner #(.SYNC_STAGES(S), .WAIT_CYCLES(W)) dut (
    .clk(clk), .reset(reset), .noisy_in(noisy_in),
    .clean_out(clean_out), .busy(busy), .glitch_count(glitch_count)
  );
  always #5 clk = ~clk;
  // expected outputs at edge k after a steady new level first gets sampled at edge 1
  function automatic exp_t rise_exp(input int k, input logic [7:0] g);
    return '{clean: k >= LAT, busy: k >= S + 1 && k <= S + W, glitch: g};
  endfunction
  task automatic tick(input logic n, input logic r);
    noisy_in = n;
    reset    = r;
    @(posedge clk);
    #1;
  endtask
  task automatic do_reset();
    repeat (3) tick(1'b0, 1'b1);
  endtask
  task automatic test_reset();
    do_reset();
    for (int k = 1; k <= 10; k++) begin
      q.push_back(rise_exp(k, 8'd0));
      tick(1'b1, 1'b0);
      e = q.pop_front();
      total++;
      if ({clean_out, busy, glitch_count} !== e) begin
        bad++;
        $display("FAIL reset_prerise edge %0d: got=%b want=%b", k, {clean_out, busy, glitch_count}, e);
      end
    end
    for (int k = 1; k <= 4; k++) begin
      q.push_back('0);
      tick(1'b1, 1'b1);
      e = q.pop_front();
      total++;
      if ({clean_out, busy, glitch_count} !== e) begin
        bad++;
        $display("FAIL reset_held edge %0d: got=%b want=%b", k, {clean_out, busy, glitch_count}, e);
      end
    end
    for (int k = 1; k <= 9; k++) begin
      q.push_back(rise_exp(k, 8'd0));
      tick(1'b1, 1'b0);
      e = q.pop_front();
      total++;
      if ({clean_out, busy, glitch_count} !== e) begin
        bad++;
        $display("FAIL reset_requalify edge %0d: got=%b want=%b", k, {clean_out, busy, glitch_count}, e);
      end
    end
  endtask
  task automatic test_clean_rise();
    do_reset();
    for (int k = 1; k <= 12; k++) begin
      q.push_back(rise_exp(k, 8'd0));
      tick(1'b1, 1'b0);
      e = q.pop_front();
      total++;
      if ({clean_out, busy, glitch_count} !== e) begin
        bad++;
        $display("FAIL clean_rise edge %0d: got=%b want=%b", k, {clean_out, busy, glitch_count}, e);
      end
    end
  endtask
  task automatic test_glitch();
    do_reset();
    for (int k = 1; k <= 10; k++) begin
      q.push_back('{clean: 1'b0, busy: k == 3 || k == 4, glitch: k >= 5 ? 8'd1 : 8'd0});
      tick(k <= 2, 1'b0);
      e = q.pop_front();
      total++;
      if ({clean_out, busy, glitch_count} !== e) begin
        bad++;
        $display("FAIL glitch edge %0d: got=%b want=%b", k, {clean_out, busy, glitch_count}, e);
      end
    end
  endtask
  task automatic test_bounce();
    int lens[5] = '{1, 2, 3, 1, 2};
    int   rises = 0;
    int   early = 0;
    logic prev;
    do_reset();
    prev = clean_out;
    for (int p = 0; p < 5; p++) begin
      for (int c = 0; c < lens[p] + 2; c++) begin
        tick(c < lens[p], 1'b0);
        if (clean_out) early++;
      end
    end
    q.push_back('{clean: 1'b1, busy: 1'b0, glitch: 8'd5});
    for (int k = 1; k <= 12; k++) begin
      tick(1'b1, 1'b0);
      if (clean_out && !prev) rises++;
      prev = clean_out;
    end
    e = q.pop_front();
    total++;
    if ({clean_out, busy, glitch_count} !== e) begin
      bad++;
      $display("FAIL bounce_final: got=%b want=%b", {clean_out, busy, glitch_count}, e);
    end
    total++;
    if (rises !== 1 || early !== 0) begin
      bad++;
      $display("FAIL bounce_edges: got rises=%0d early_high=%0d want rises=1 early_high=0", rises, early);
    end
  endtask
  task automatic test_mid_reset();
    do_reset();
    for (int k = 1; k <= 14; k++) begin
      q.push_back(k <= 3 ? rise_exp(k, 8'd0) : (k <= 5 ? exp_t'('0) : rise_exp(k - 5, 8'd0)));
      tick(1'b1, k == 4 || k == 5);
      e = q.pop_front();
      total++;
      if ({clean_out, busy, glitch_count} !== e) begin
        bad++;
        $display("FAIL mid_reset edge %0d: got=%b want=%b", k, {clean_out, busy, glitch_count}, e);
      end
    end
  endtask
  task automatic test_saturation();
    do_reset();
    for (int p = 0; p < 254; p++) begin
      tick(1'b1, 1'b0); tick(1'b1, 1'b0); tick(1'b0, 1'b0); tick(1'b0, 1'b0);
    end
    q.push_back('{clean: 1'b0, busy: 1'b0, glitch: 8'd254});
    repeat (4) tick(1'b0, 1'b0);
    e = q.pop_front();
    total++;
    if ({clean_out, busy, glitch_count} !== e) begin
      bad++;
      $display("FAIL sat_254: got=%b want=%b", {clean_out, busy, glitch_count}, e);
    end
    for (int p = 0; p < 46; p++) begin
      tick(1'b1, 1'b0); tick(1'b1, 1'b0); tick(1'b0, 1'b0); tick(1'b0, 1'b0);
    end
    q.push_back('{clean: 1'b0, busy: 1'b0, glitch: 8'd255});
    repeat (4) tick(1'b0, 1'b0);
    e = q.pop_front();
    total++;
    if ({clean_out, busy, glitch_count} !== e) begin
      bad++;
      $display("FAIL sat_255: got=%b want=%b", {clean_out, busy, glitch_count}, e);
    end
    q.push_back('0);
    tick(1'b0, 1'b1);
    e = q.pop_front();
    total++;
    if ({clean_out, busy, glitch_count} !== e) begin
      bad++;
      $display("FAIL sat_reset: got=%b want=%b", {clean_out, busy, glitch_count}, e);
    end
  endtask
  task automatic test_fall();
    do_reset();
    for (int k = 1; k <= 10; k++) tick(1'b1, 1'b0);
    for (int k = 1; k <= 10; k++) begin
      q.push_back('{clean: k < LAT, busy: k >= S + 1 && k <= S + W, glitch: 8'd0});
      tick(1'b0, 1'b0);
      e = q.pop_front();
      total++;
      if ({clean_out, busy, glitch_count} !== e) begin
        bad++;
        $display("FAIL fall edge %0d: got=%b want=%b", k, {clean_out, busy, glitch_count}, e);
      end
    end
    for (int k = 1; k <= 10; k++) tick(1'b1, 1'b0);
    for (int k = 1; k <= 8; k++) begin
      q.push_back('{clean: 1'b1, busy: k == 3 || k == 4, glitch: k >= 5 ? 8'd1 : 8'd0});
      tick(k > 2, 1'b0);
      e = q.pop_front();
      total++;
      if ({clean_out, busy, glitch_count} !== e) begin
        bad++;
        $display("FAIL fall_blip edge %0d: got=%b want=%b", k, {clean_out, busy, glitch_count}, e);
      end
    end
  endtask
  initial begin
    test_reset();
    test_clean_rise();
    test_glitch();
    test_bounce();
    test_mid_reset();
    test_saturation();
    test_fall();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
